// File: rtl/angledist_pkg.sv
// Shared types for the angle-distance pipeline: distance word, library size default and search FSM states.
package angledist_pkg;

    localparam int DIST_W       = 16;
    localparam int NUM_REFS_DEF = 16;

    typedef logic [DIST_W-1:0] dist_t;

    localparam dist_t DIST_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } argmin_state_t;

endpackage

// File: rtl/dist_argmin.sv
// Purpose: streams NUM_REFS library distances and reports the closest entry, the runner-up and a threshold match.
// Latency: done_o and the result outputs update 1 cycle after the final accepted distance.
// Backpressure: dist_ready_o is high only while searching; distances offered in any other state are dropped.
module dist_argmin
    import angledist_pkg::*;
#(
    parameter int NUM_REFS = NUM_REFS_DEF,
    parameter int IW       = $clog2(NUM_REFS)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          start_i,
    input  dist_t         thresh_i,
    input  logic          dist_valid_i,
    input  dist_t         dist_i,
    output logic          dist_ready_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [IW-1:0] best_idx_o,
    output dist_t         best_dist_o,
    output dist_t         second_dist_o,
    output logic          match_o
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REFS - 1);

    argmin_state_t state_q, state_d;
    logic [IW-1:0] cnt_q;
    logic [IW-1:0] idx_q, idx_nx;
    dist_t         best_q, best_nx;
    dist_t         sec_q, sec_nx;
    dist_t         thresh_q;

    logic          acc;
    logic          last_acc;
    logic          start_ld;

    assign acc      = (state_q == ST_RUN) && dist_valid_i;
    assign last_acc = acc && (cnt_q == LAST_IDX);
    // start is honoured from IDLE and DONE only, so back-to-back searches skip IDLE
    assign start_ld = start_i && (state_q != ST_RUN);

    // Two-level minimum: strict compares keep the earliest index on ties.
    always_comb begin
        best_nx = best_q;
        sec_nx  = sec_q;
        idx_nx  = idx_q;
        if (acc) begin
            if (dist_i < best_q) begin
                sec_nx  = best_q;
                best_nx = dist_i;
                idx_nx  = cnt_q;
            end else if (dist_i < sec_q) begin
                sec_nx = dist_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_i)  state_d = ST_RUN;
            ST_RUN:  if (last_acc) state_d = ST_DONE;
            ST_DONE: state_d = start_i ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            best_q        <= DIST_MAX;
            sec_q         <= DIST_MAX;
            thresh_q      <= '0;
            best_idx_o    <= '0;
            best_dist_o   <= '0;
            second_dist_o <= '0;
            match_o       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ld) begin
                cnt_q    <= '0;
                idx_q    <= '0;
                best_q   <= DIST_MAX;
                sec_q    <= DIST_MAX;
                thresh_q <= thresh_i;
            end else if (acc) begin
                idx_q  <= idx_nx;
                best_q <= best_nx;
                sec_q  <= sec_nx;
                if (!last_acc) cnt_q <= cnt_q + IW'(1);
            end
            // Results are taken from the post-update values so the final distance counts.
            if (last_acc) begin
                best_idx_o    <= idx_nx;
                best_dist_o   <= best_nx;
                second_dist_o <= sec_nx;
                match_o       <= (best_nx <= thresh_q);
            end
        end
    end

    assign dist_ready_o = (state_q == ST_RUN);
    assign busy_o       = (state_q == ST_RUN);
    assign done_o       = (state_q == ST_DONE);

endmodule

// File: doc/dist_argmin.md
DIST_ARGMIN -- requirements
Module: dist_argmin

Interface
REQ-001 Parameter NUM_REFS, default 16, number of library distances per search; SHALL be >= 2.
REQ-002 Parameter IW, default $clog2(NUM_REFS), index width.
REQ-003 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rstn_i  input  1  reset, synchronous, active-low.
REQ-005 start_i  input  1  begin a new search; thresh_i is sampled in the same cycle.
REQ-006 thresh_i  input  16  unsigned match threshold.
REQ-007 dist_valid_i  input  1  dist_i carries a distance.
REQ-008 dist_i  input  16  unsigned distance from the angle-distance stage; lower means closer.
REQ-009 dist_ready_o  output  1  block accepts dist_i this cycle.
REQ-010 busy_o  output  1  search in progress.
REQ-011 done_o  output  1  one-cycle pulse when results update.
REQ-012 best_idx_o  output  IW  index of the minimum distance.
REQ-013 best_dist_o  output  16  minimum distance.
REQ-014 second_dist_o  output  16  runner-up distance.
REQ-015 match_o  output  1  best_dist_o <= sampled threshold.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 IDLE: dist_ready_o=0 and busy_o=0; start_i=1 SHALL move to RUN on the next cycle and SHALL clear the count to 0, load the running best and runner-up to 16'hFFFF, load the running index to 0, and latch thresh_i.
REQ-018 RUN: dist_ready_o=1 and busy_o=1; an accept occurs when dist_valid_i && dist_ready_o, and assigns entry index = count.
REQ-019 On an accept with dist_i < best: runner-up SHALL take the old best, best SHALL take dist_i, and index SHALL take count.
REQ-020 On an accept with best <= dist_i < runner-up: runner-up SHALL take dist_i.
REQ-021 Comparisons SHALL be unsigned and strict, so a tie keeps the lower index.
REQ-022 A non-accept cycle in RUN SHALL leave count and running values unchanged, so valid gaps are tolerated.
REQ-023 The accept at count == NUM_REFS-1 SHALL move to DONE; otherwise count SHALL increment by 1 with no wrap.
REQ-024 DONE lasts one cycle: done_o=1; result outputs SHALL be registered from the final running values on DONE entry; dist_ready_o=0.
REQ-025 Result outputs SHALL otherwise hold their last values, including throughout a subsequent RUN.
REQ-026 DONE with start_i=1 SHALL go directly to RUN with REQ-017 initialisation; otherwise DONE SHALL go to IDLE.
REQ-027 start_i in RUN SHALL be ignored.
REQ-028 dist_valid_i in IDLE or DONE SHALL be ignored.
REQ-029 Latency SHALL be 1 cycle from the final accept to done_o.

Reset
REQ-030 With rstn_i=0 at a clock edge: state=IDLE, count=0, all result outputs=0, match_o=0, done_o=0, busy_o=0, dist_ready_o=0.
REQ-031 Reset during RUN SHALL abandon the search with no done_o pulse.

Structure
REQ-032 The 16-bit distance typedef and NUM_REFS default SHALL live in the shared package angledist_pkg, which is reused by angle-distance stages.
REQ-033 No sub-module SHALL be used: one FSM, one counter and an inline two-level minimum tracker.

Verification (NUM_REFS=4)
REQ-034 Stream 5,3,3,9, thresh 4 -> done_o after the 4th accept, best_idx_o=1, best_dist_o=3, second_dist_o=3, match_o=1.
REQ-035 Stream FFFF x4 -> best_idx_o=0, best_dist_o=FFFF, second_dist_o=FFFF, match_o=0 for thresh FFFE.
REQ-036 Stream 9,_,_,7,_,2,8 with valid gaps (_) -> exactly 4 accepts, best_idx_o=2, best_dist_o=2, second_dist_o=7.
REQ-037 rstn_i=0 after 2 accepts -> no done_o, outputs 0; a new search of 4,1,6,0 -> best_idx_o=3, best_dist_o=0, second_dist_o=1.
REQ-038 start_i held high through DONE -> back-to-back searches; start_i pulses mid-RUN do not restart the count; results stay stable until the next done_o.
